// File: rtl/clock_ctrl.sv
// Clock sequencer: 1 Hz prescaler, RUN carry forwarding between counter
// stages, and the time-set FSM with increment auto-repeat and field blink.
module clock_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int HOLD_CYC   = 25000000,
    parameter int REPEAT_CYC = 5000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_mode,
    input  logic       i_inc,
    input  logic       i_sec_carry,
    input  logic       i_min_carry,
    output logic       o_sec_en,
    output logic       o_min_en,
    output logic       o_hr_en,
    output logic [1:0] o_mode,
    output logic       o_tick,
    output logic       o_blink
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(TICK_DIV / 2 + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int RW = $clog2(REPEAT_CYC + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(TICK_DIV / 2 - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYC);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_SET_HR  = 2'd1;
    localparam logic [1:0] ST_SET_MIN = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [PW-1:0] pre_cnt;
    logic [BW-1:0] blink_cnt;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic          inc_prev;
    logic          armed;

    logic stay_run, in_set, inc_rise, counting, rep_fire, inc_pulse, tick_hit;

    // NOTE: always_comb assigns a default before any branch so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (i_mode) begin
            case (state)
                ST_RUN:    state_nxt = ST_SET_HR;
                ST_SET_HR: state_nxt = ST_SET_MIN;
                default:   state_nxt = ST_RUN;
            endcase
        end
    end

    // A mode pulse counts as leaving the current state, so carries and ticks
    // sampled on the transition edge are dropped rather than leaking through.
    assign stay_run = (state == ST_RUN) && !i_mode;
    assign in_set   = (state != ST_RUN) && !i_mode;
    assign tick_hit = stay_run && (pre_cnt == PRE_LAST);
    assign inc_rise = i_inc && !inc_prev;

    // Auto-repeat only runs for a press that started in this state; a hold
    // carried across a mode change stays disarmed until released.
    assign counting  = in_set && i_inc && (inc_rise || armed);
    assign rep_fire  = (hold_cnt == HOLD_LAST) ||
                       ((hold_cnt == HOLD_SAT) && (rep_cnt == REP_LAST));
    assign inc_pulse = in_set && (inc_rise || (counting && rep_fire));

    assign o_mode = state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_RUN;
            pre_cnt   <= '0;
            blink_cnt <= '0;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            inc_prev  <= 1'b0;
            armed     <= 1'b0;
            o_sec_en  <= 1'b0;
            o_min_en  <= 1'b0;
            o_hr_en   <= 1'b0;
            o_tick    <= 1'b0;
            o_blink   <= 1'b1;
        end else begin
            state    <= state_nxt;
            inc_prev <= i_inc;

            if (stay_run && !tick_hit) begin
                pre_cnt <= pre_cnt + PW'(1);
            end else begin
                pre_cnt <= '0;
            end

            o_tick   <= tick_hit;
            o_sec_en <= tick_hit;
            o_min_en <= (stay_run && i_sec_carry) || (inc_pulse && state == ST_SET_MIN);
            o_hr_en  <= (stay_run && i_min_carry) || (inc_pulse && state == ST_SET_HR);

            if (!counting) begin
                armed    <= 1'b0;
                hold_cnt <= '0;
                rep_cnt  <= '0;
            end else begin
                armed <= 1'b1;
                if (hold_cnt != HOLD_SAT) begin
                    hold_cnt <= hold_cnt + HW'(1);
                    rep_cnt  <= '0;
                end else if (rep_cnt == REP_LAST) begin
                    rep_cnt <= '0;
                end else begin
                    rep_cnt <= rep_cnt + RW'(1);
                end
            end

            if (!in_set) begin
                blink_cnt <= '0;
                o_blink   <= 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                o_blink   <= ~o_blink;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Sequencer for the digital clock's three chained mod-N counters: seconds, minutes and hours.
- Generates the 1 Hz tick from the system clock.
- Forwards carry pulses between counter stages in normal running.
- Provides the time-set FSM: select a field with a mode button, then advance it with an increment button that auto-repeats while held.
- Sits between the debounced-button front end and the counter instances; also drives the display's field-blink control.

Parameters:
TICK_DIV, 50000000, system clocks per 1 Hz tick (>=4, even)
HOLD_CYC, 25000000, clocks i_inc must be held before auto-repeat starts (>=1)
REPEAT_CYC, 5000000, clocks between auto-repeat pulses (>=1)

Ports:
i_clk  in  1  system clock, all logic on posedge
i_rst  in  1  reset, synchronous, active-high
i_mode  in  1  debounced one-cycle pulse, advances set FSM
i_inc  in  1  debounced level, increment button (high = pressed)
i_sec_carry  in  1  seconds counter o_en (wrap pulse)
i_min_carry  in  1  minutes counter o_en (wrap pulse)
o_sec_en  out  1  one-cycle enable to seconds counter
o_min_en  out  1  one-cycle enable to minutes counter
o_hr_en  out  1  one-cycle enable to hours counter
o_mode  out  2  0=RUN, 1=SET_HR, 2=SET_MIN (3 never driven)
o_tick  out  1  one-cycle 1 Hz strobe (RUN only)
o_blink  out  1  display enable for selected field; 1 in RUN

Behaviour:
- All outputs are registered. Reset state:
  - FSM = RUN; o_mode=0.
  - o_sec_en, o_min_en, o_hr_en and o_tick = 0; o_blink=1.
  - Prescaler, hold counter, repeat counter and blink counter = 0.
  - Previous-i_inc register = 0.
- Reset beats every other input in the same cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; held at 0 in SET states.
  - o_tick=1 for exactly the cycle after the count equals TICK_DIV-1; the count then wraps to 0.
  - On entry to RUN it restarts from 0, so the first o_tick arrives TICK_DIV cycles after the transition.
- RUN forwarding, each a one-cycle pulse with one register stage:
  - o_sec_en = o_tick.
  - o_min_en = i_sec_carry delayed 1 cycle.
  - o_hr_en = i_min_carry delayed 1 cycle.
  - Hour wrap is not tracked.
- FSM, transitions on i_mode=1 only: RUN -> SET_HR -> SET_MIN -> RUN. The new o_mode is visible the cycle after the pulse.
- SET states:
  - Prescaler frozen; o_tick=0.
  - i_sec_carry and i_min_carry are ignored. A field wrap while setting must not ripple to the next field. A carry sampled in a SET state is dropped, including one in flight at a RUN->SET transition.
  - Rising edge of i_inc (prev=0, now=1) gives one o_hr_en pulse (SET_HR) or one o_min_en pulse (SET_MIN) next cycle.
  - Auto-repeat:
    - Hold counter counts while i_inc stays high.
    - After HOLD_CYC cycles of continuous hold, the first repeat pulse is emitted.
    - Further pulses follow every REPEAT_CYC cycles while i_inc stays high.
    - Release clears the hold and repeat counters.
  - o_sec_en is never asserted in SET states.
- Simultaneous i_mode and i_inc edge in the same cycle: mode wins, no increment pulse. The edge register still updates, so holding across the mode change needs a release and re-press to increment the new field.
- Any state change clears the hold, repeat and blink counters.
- Blink:
  - In SET states o_blink toggles every TICK_DIV/2 cycles, starting at 1 on state entry.
  - o_blink=1 constantly in RUN.
- At most one of o_sec_en, o_min_en, o_hr_en is driven by the increment path per cycle. RUN forwarding may legitimately pulse several in the same cycle.

Test Plan:
Bench parameters: TICK_DIV=10, HOLD_CYC=6, REPEAT_CYC=3.
1. Release reset, idle 35 cycles -> o_tick and o_sec_en pulse at cycles 10, 20, 30 after reset release; o_mode=0, o_blink=1 throughout.
2. In RUN, pulse i_sec_carry at cycle N -> o_min_en=1 at N+1 only. Pulse i_min_carry at M -> o_hr_en=1 at M+1.
3. Pulse i_mode once, then raise i_inc for 2 cycles -> o_mode=1; exactly one o_hr_en pulse; o_tick stays 0; o_blink toggles every 5 cycles.
4. In SET_MIN, hold i_inc 15 cycles -> o_min_en pulses at edge+1, hold+6, +9, +12, +15 (5 total). Assert i_sec_carry and i_min_carry during the hold -> no extra o_min_en/o_hr_en.
5. i_mode and i_inc rising in the same cycle in SET_HR -> o_mode goes to 2, no o_hr_en or o_min_en pulse. Third i_mode pulse -> RUN, first o_tick exactly 10 cycles later.
6. Assert i_rst while in SET_MIN mid-repeat -> next cycle o_mode=0, all enables 0, o_blink=1. The prescaler restarts: first tick 10 cycles after i_rst is deasserted.
